// File: rtl/data_bus_arbiter.sv
// Two-master data-bus write arbiter: debug has priority, with a starvation guard that lets the CPU in
// after MAX_DBG consecutive debug grants. Each transfer is IDLE -> SETUP -> WRITE -> RELEASE.
module data_bus_arbiter #(
    parameter int TIMEOUT = 15,
    parameter int MAX_DBG = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic [1:0] cpu_sel,
    input  logic       dbg_req,
    input  logic [1:0] dbg_sel,
    input  logic       mem_ready,
    output logic       cpu_gnt,
    output logic       dbg_gnt,
    output logic [1:0] data_busx,
    output logic       wr,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [1:0] DATA_BUSX_REGA_DOUT = 2'b00;
    localparam logic [3:0] MAX_DBG_CNT         = 4'(MAX_DBG);
    localparam logic [7:0] WAIT_LAST           = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        WRITE   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t     state;
    logic [3:0] dbg_streak;
    logic [7:0] wait_cnt;
    logic       cpu_wins;
    logic [3:0] streak_inc;

    // Arbitration decision and saturating streak increment for the current IDLE cycle
    always_comb begin
        cpu_wins   = 1'b0;
        streak_inc = dbg_streak;
        if (cpu_req && (!dbg_req || (dbg_streak == MAX_DBG_CNT))) begin
            cpu_wins = 1'b1;
        end else begin
            cpu_wins = 1'b0;
        end
        if (dbg_streak >= MAX_DBG_CNT) begin
            streak_inc = MAX_DBG_CNT;
        end else begin
            streak_inc = dbg_streak + 4'd1;
        end
    end

    // Transfer FSM; every output is registered together with the state it belongs to
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cpu_gnt    <= 1'b0;
            dbg_gnt    <= 1'b0;
            data_busx  <= DATA_BUSX_REGA_DOUT;
            wr         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            dbg_streak <= 4'd0;
            wait_cnt   <= 8'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_wins) begin
                        state      <= SETUP;
                        cpu_gnt    <= 1'b1;
                        data_busx  <= cpu_sel;
                        busy       <= 1'b1;
                        dbg_streak <= 4'd0;
                    end else if (dbg_req) begin
                        state     <= SETUP;
                        dbg_gnt   <= 1'b1;
                        data_busx <= dbg_sel;
                        busy      <= 1'b1;
                        // The streak only measures how long a pending CPU request has waited
                        dbg_streak <= cpu_req ? streak_inc : 4'd0;
                    end else begin
                        dbg_streak <= 4'd0;
                    end
                end
                SETUP: begin
                    state    <= WRITE;
                    wr       <= 1'b1;
                    wait_cnt <= 8'd0;
                end
                WRITE: begin
                    if (mem_ready) begin
                        state <= RELEASE;
                        wr    <= 1'b0;
                        done  <= 1'b1;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= RELEASE;
                        wr    <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RELEASE: begin
                    state     <= IDLE;
                    cpu_gnt   <= 1'b0;
                    dbg_gnt   <= 1'b0;
                    data_busx <= DATA_BUSX_REGA_DOUT;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    cpu_gnt   <= 1'b0;
                    dbg_gnt   <= 1'b0;
                    data_busx <= DATA_BUSX_REGA_DOUT;
                    wr        <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
